// File: rtl/pr_timer_pkg.sv
// pr_timer_pkg: shared definitions for the pr_timer processor-bus interval timer.
//   - state_t           : timer FSM states (IDLE/LOAD/CNT/INT)
//   - *_OFS             : register word offsets within the 16-byte window
//   - EN_B/MODE_LSB/IM_B: CTRL register bit positions
//   - MODE_*            : CTRL.MODE encodings
//   - ctrl_word()       : packs CTRL fields into the 32-bit read value
package pr_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [1:0] CTRL_OFS   = 2'd0;
    localparam logic [1:0] PRESET_OFS = 2'd1;
    localparam logic [1:0] COUNT_OFS  = 2'd2;

    localparam int unsigned EN_B     = 0;
    localparam int unsigned MODE_LSB = 1;
    localparam int unsigned IM_B     = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

    function automatic logic [31:0] ctrl_word(input logic en, input logic [1:0] mode,
                                              input logic im);
        return {28'd0, im, mode, en};
    endfunction

endpackage

// File: rtl/pr_timer.sv
// pr_timer: memory-mapped interval timer on the CPU processor bus.
// Decodes a 16-byte window at BASE, serves combinational register reads,
// accepts single-cycle writes, counts down from PRESET and raises IRQ.
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   asynchronous active-low reset
//   PrAddr  in   bus byte address ([1:0] ignored)
//   PrWE    in   write strobe
//   PrWD    in   write data
//   PrRD    out  read data (combinational, 0 when not hit)
//   hit     out  address falls inside this device's window
//   IRQ     out  interrupt request (IM & irq flag)
module pr_timer
    import pr_timer_pkg::*;
#(
    parameter logic [31:0] BASE = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PrAddr,
    input  logic        PrWE,
    input  logic [31:0] PrWD,
    output logic [31:0] PrRD,
    output logic        hit,
    output logic        IRQ
);

    state_t      r_state;
    logic        r_en;
    logic [1:0]  r_mode;
    logic        r_im;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_irq_flag;

    logic        w_hit;
    logic [1:0]  w_ofs;
    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_en_next;
    logic [31:0] w_rd;
    logic        w_unused_addr;

    assign w_hit         = (PrAddr[31:4] == BASE[31:4]);
    assign w_ofs         = PrAddr[3:2];
    assign w_wr_ctrl     = PrWE && w_hit && (w_ofs == CTRL_OFS);
    assign w_wr_preset   = PrWE && w_hit && (w_ofs == PRESET_OFS);
    assign w_unused_addr = ^PrAddr[1:0];

    // IDLE reacts to an enable written on this very edge, so the load
    // happens one edge after the CTRL write rather than two.
    assign w_en_next = w_wr_ctrl ? PrWD[EN_B] : r_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_en       <= 1'b0;
            r_mode     <= MODE_ONESHOT;
            r_im       <= 1'b0;
            r_preset   <= '0;
            r_count    <= '0;
            r_irq_flag <= 1'b0;
        end else begin
            // Write-clear comes first so an FSM set on the same edge wins.
            if (w_wr_ctrl || w_wr_preset) begin
                r_irq_flag <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_en_next) begin
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_count <= r_preset;
                    r_state <= CNT;
                end
                CNT: begin
                    // Uses the registered EN: a disabling write still lets
                    // this edge decrement, counting stops on the next one.
                    if (!r_en) begin
                        r_state <= IDLE;
                    end else if (r_count > 32'd1) begin
                        r_count <= r_count - 32'd1;
                    end else begin
                        r_count    <= '0;
                        r_irq_flag <= 1'b1;
                        r_state    <= INT;
                    end
                end
                INT: begin
                    if (r_mode == MODE_RELOAD) begin
                        r_irq_flag <= 1'b0;
                        r_count    <= r_preset;
                        r_state    <= CNT;
                    end else begin
                        r_en    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            // Register writes come last so a written EN overrides the
            // one-shot auto-disable on the same edge.
            if (w_wr_ctrl) begin
                r_en   <= PrWD[EN_B];
                r_mode <= PrWD[MODE_LSB +: 2];
                r_im   <= PrWD[IM_B];
            end
            if (w_wr_preset) begin
                r_preset <= PrWD;
            end
        end
    end

    always_comb begin
        w_rd = '0;
        case (w_ofs)
            CTRL_OFS:   w_rd = ctrl_word(r_en, r_mode, r_im);
            PRESET_OFS: w_rd = r_preset;
            COUNT_OFS:  w_rd = r_count;
            default:    w_rd = '0;
        endcase
    end

    assign PrRD = w_hit ? w_rd : '0;
    assign hit  = w_hit;
    assign IRQ  = r_im & r_irq_flag;

endmodule

// File: tb/tb_pr_timer.sv
// tb_pr_timer: self-checking bench for pr_timer. Expected values come from
// closed-form timing rules (load one edge after enable, flag max(P,1)+1 edges
// after enable, reload period P+1) rather than a cycle-level FSM copy.
module tb_pr_timer;

    localparam logic [31:0] BASE = 32'h0000_7F00;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PrAddr;
    logic        PrWE;
    logic [31:0] PrWD;
    logic [31:0] PrRD;
    logic        hit;
    logic        IRQ;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    pr_timer #(.BASE(BASE)) dut (
        .clk    (clk),
        .reset  (reset),
        .PrAddr (PrAddr),
        .PrWE   (PrWE),
        .PrWD   (PrWD),
        .PrRD   (PrRD),
        .hit    (hit),
        .IRQ    (IRQ)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        PrAddr = a;
        PrWD   = d;
        PrWE   = 1'b1;
        @(posedge clk);
        #1;
        PrWE   = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        PrAddr = a;
        #1;
        d = PrRD;
    endtask

    task automatic apply_reset();
        PrWE   = 1'b0;
        PrAddr = BASE;
        PrWD   = '0;
        reset  = 1'b0;
        tick();
        tick();
        reset  = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        PrWE = 1'b0; PrWD = '0; PrAddr = BASE + 32'd8;
        reset = 1'b0;
        #3;
        vecs++; if (PrRD !== 32'h0) begin errs++; $display("FAIL reset_prrd: got %h expected %h", PrRD, 32'h0); end
        vecs++; if (IRQ !== 1'b0) begin errs++; $display("FAIL reset_irq: got %b expected 0", IRQ); end
        vecs++; if (hit !== 1'b1) begin errs++; $display("FAIL reset_hit: got %b expected 1", hit); end
        reset = 1'b1;
        tick();
        bus_write(BASE, 32'hFFFF_FFFF);
        rd(BASE, d);
        vecs++; if (d !== 32'h0000_000F) begin errs++; $display("FAIL ctrl_mask: got %h expected %h", d, 32'h0000_000F); end
    endtask

    task automatic test_oneshot(input int unsigned p, input logic im, input logic [1:0] mode);
        int unsigned kset;
        logic [31:0] expc, d, newp;
        logic        expi;
        apply_reset();
        bus_write(BASE + 32'd4, 32'(p));
        bus_write(BASE, {28'd0, im, mode, 1'b1});
        kset = ((p == 0) ? 1 : p) + 1;
        PrAddr = BASE + 32'd8;
        for (int unsigned k = 1; k <= kset + 2; k++) begin
            tick();
            expc = (k < kset) ? 32'(p) - 32'(k - 1) : 32'd0;
            expi = im && (k >= kset);
            vecs++; if (PrRD !== expc) begin errs++; $display("FAIL oneshot_count p=%0d k=%0d: got %h expected %h", p, k, PrRD, expc); end
            vecs++; if (IRQ !== expi) begin errs++; $display("FAIL oneshot_irq p=%0d k=%0d: got %b expected %b", p, k, IRQ, expi); end
        end
        rd(BASE, d);
        vecs++; if (d !== {28'd0, im, mode, 1'b0}) begin errs++; $display("FAIL oneshot_en_clear: got %h expected %h", d, {28'd0, im, mode, 1'b0}); end
        newp = $urandom;
        PrAddr = BASE + 32'd4; PrWD = newp; PrWE = 1'b1;
        #1;
        vecs++; if (PrRD !== 32'(p)) begin errs++; $display("FAIL read_during_write: got %h expected %h", PrRD, 32'(p)); end
        vecs++; if (IRQ !== im) begin errs++; $display("FAIL irq_before_clear: got %b expected %b", IRQ, im); end
        @(posedge clk);
        #1;
        PrWE = 1'b0;
        vecs++; if (IRQ !== 1'b0) begin errs++; $display("FAIL irq_clear_preset: got %b expected 0", IRQ); end
        rd(BASE + 32'd4, d);
        vecs++; if (d !== newp) begin errs++; $display("FAIL preset_rw: got %h expected %h", d, newp); end
    endtask

    task automatic test_reload(input int unsigned p);
        int unsigned k1, kend, knew;
        logic        expi;
        apply_reset();
        bus_write(BASE + 32'd4, 32'(p));
        bus_write(BASE, 32'h0000_000B);
        k1 = p + 1;
        kend = k1 + 3 * (p + 1);
        for (int unsigned k = 1; k <= kend; k++) begin
            tick();
            expi = (k >= k1) && (((k - k1) % (p + 1)) == 0);
            vecs++; if (IRQ !== expi) begin errs++; $display("FAIL reload_irq p=%0d k=%0d: got %b expected %b", p, k, IRQ, expi); end
        end
        // PRESET=1 written mid-count: current period unchanged, then period 2.
        knew = kend + p + 1;
        for (int unsigned k = kend + 1; k <= knew + 8; k++) begin
            if (k == kend + 2) bus_write(BASE + 32'd4, 32'd1);
            else tick();
            expi = (k >= knew) && (((k - knew) % 2) == 0);
            vecs++; if (IRQ !== expi) begin errs++; $display("FAIL reload_newp p=%0d k=%0d: got %b expected %b", p, k, IRQ, expi); end
        end
    endtask

    task automatic test_pause(input int unsigned p, input int unsigned w);
        logic [31:0] expc;
        apply_reset();
        bus_write(BASE + 32'd4, 32'(p));
        bus_write(BASE, 32'h0000_0009);
        for (int unsigned k = 1; k <= w; k++) begin
            if (k == w) bus_write(BASE, 32'h0);
            else tick();
            PrAddr = BASE + 32'd8;
            #1;
            expc = 32'(p) - 32'(k - 1);
            vecs++; if (PrRD !== expc) begin errs++; $display("FAIL pause_count k=%0d: got %h expected %h", k, PrRD, expc); end
        end
        expc = 32'(p) - 32'(w - 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            vecs++; if (PrRD !== expc) begin errs++; $display("FAIL pause_hold: got %h expected %h", PrRD, expc); end
            vecs++; if (IRQ !== 1'b0) begin errs++; $display("FAIL pause_irq: got %b expected 0", IRQ); end
        end
        bus_write(BASE, 32'h0000_0009);
        tick();
        PrAddr = BASE + 32'd8;
        #1;
        vecs++; if (PrRD !== 32'(p)) begin errs++; $display("FAIL pause_reload: got %h expected %h", PrRD, 32'(p)); end
    endtask

    task automatic test_im0();
        logic [31:0] d, a;
        apply_reset();
        bus_write(BASE + 32'd4, 32'd2);
        bus_write(BASE, 32'h0000_0001);
        for (int i = 0; i < 6; i++) begin
            tick();
            vecs++; if (IRQ !== 1'b0) begin errs++; $display("FAIL im0_irq: got %b expected 0", IRQ); end
        end
        rd(BASE, d);
        vecs++; if (d !== 32'h0) begin errs++; $display("FAIL im0_ctrl: got %h expected %h", d, 32'h0); end
        bus_write(BASE, 32'h0000_0008);
        tick();
        vecs++; if (IRQ !== 1'b0) begin errs++; $display("FAIL im0_flag_clear: got %b expected 0", IRQ); end
        for (int i = 0; i < 6; i++) begin
            a = (i == 0) ? BASE + 32'd16 : $urandom;
            if (a[31:4] == BASE[31:4]) a = a ^ 32'h0000_0100;
            PrAddr = a;
            #1;
            vecs++; if (hit !== 1'b0) begin errs++; $display("FAIL miss_hit addr=%h: got %b expected 0", a, hit); end
            vecs++; if (PrRD !== 32'h0) begin errs++; $display("FAIL miss_prrd addr=%h: got %h expected 0", a, PrRD); end
            bus_write(a, $urandom | 32'h1);
        end
        bus_write(BASE + 32'd8, 32'h1234_5678);
        bus_write(BASE + 32'd12, 32'hFFFF_FFFF);
        tick();
        rd(BASE, d);
        vecs++; if (d !== 32'h8) begin errs++; $display("FAIL miss_ctrl: got %h expected %h", d, 32'h8); end
        rd(BASE + 32'd4, d);
        vecs++; if (d !== 32'h2) begin errs++; $display("FAIL miss_preset: got %h expected %h", d, 32'h2); end
        rd(BASE + 32'd8, d);
        vecs++; if (d !== 32'h0) begin errs++; $display("FAIL count_ro: got %h expected %h", d, 32'h0); end
        rd(BASE + 32'd12, d);
        vecs++; if (d !== 32'h0) begin errs++; $display("FAIL ofs3_zero: got %h expected %h", d, 32'h0); end
        vecs++; if (IRQ !== 1'b0) begin errs++; $display("FAIL miss_irq: got %b expected 0", IRQ); end
    endtask

    task automatic test_collision(input int unsigned p, input logic [31:0] q);
        logic [31:0] d;
        int unsigned kset;
        apply_reset();
        bus_write(BASE + 32'd4, 32'(p));
        bus_write(BASE, 32'h0000_0009);
        kset = p + 1;
        for (int unsigned k = 1; k < kset; k++) tick();
        bus_write(BASE + 32'd4, q);
        vecs++; if (IRQ !== 1'b1) begin errs++; $display("FAIL set_wins: got %b expected 1", IRQ); end
        bus_write(BASE, 32'h0000_0009);
        vecs++; if (IRQ !== 1'b0) begin errs++; $display("FAIL ctrl_clear: got %b expected 0", IRQ); end
        rd(BASE, d);
        vecs++; if (d !== 32'h9) begin errs++; $display("FAIL written_en_wins: got %h expected %h", d, 32'h9); end
        tick();
        tick();
        rd(BASE + 32'd8, d);
        vecs++; if (d !== q) begin errs++; $display("FAIL restart_count: got %h expected %h", d, q); end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        apply_reset();
        bus_write(BASE + 32'd4, 32'd20);
        bus_write(BASE, 32'h0000_0009);
        for (int k = 1; k <= 14; k++) tick();
        rd(BASE + 32'd8, d);
        vecs++; if (d !== 32'd7) begin errs++; $display("FAIL prereset_count: got %h expected %h", d, 32'd7); end
        #2;
        reset = 1'b0;
        #1;
        vecs++; if (PrRD !== 32'h0) begin errs++; $display("FAIL async_count: got %h expected 0", PrRD); end
        vecs++; if (IRQ !== 1'b0) begin errs++; $display("FAIL async_irq: got %b expected 0", IRQ); end
        rd(BASE + 32'd4, d);
        vecs++; if (d !== 32'h0) begin errs++; $display("FAIL async_preset: got %h expected 0", d); end
        rd(BASE, d);
        vecs++; if (d !== 32'h0) begin errs++; $display("FAIL async_ctrl: got %h expected 0", d); end
        reset = 1'b1;
        bus_write(BASE + 32'd4, 32'd3);
        PrAddr = BASE + 32'd8;
        for (int i = 0; i < 25; i++) begin
            tick();
            vecs++; if (PrRD !== 32'h0 || IRQ !== 1'b0) begin errs++; $display("FAIL post_reset_idle: got count=%h irq=%b expected 0/0", PrRD, IRQ); end
        end
        bus_write(BASE, 32'h0000_0009);
        tick();
        rd(BASE + 32'd8, d);
        vecs++; if (d !== 32'd3) begin errs++; $display("FAIL post_reset_enable: got %h expected %h", d, 32'd3); end
    endtask

    initial begin
        int unsigned p, w;
        logic [1:0]  m;
        reset = 1'b0; PrWE = 1'b0; PrAddr = BASE; PrWD = '0;
        test_reset();
        test_oneshot(5, 1'b1, 2'd0);
        test_oneshot(0, 1'b1, 2'd2);
        test_oneshot(1, 1'b1, 2'd3);
        for (int i = 0; i < 4; i++) begin
            m = 2'($urandom_range(0, 2));
            if (m != 2'd0) m = m + 2'd1;
            test_oneshot($urandom_range(0, 12), 1'($urandom_range(0, 1)), m);
        end
        test_reload(3);
        for (int i = 0; i < 2; i++) test_reload($urandom_range(2, 6));
        test_pause(10, 5);
        for (int i = 0; i < 2; i++) begin
            p = $urandom_range(6, 30);
            w = $urandom_range(2, p - 1);
            test_pause(p, w);
        end
        test_im0();
        test_collision(2, 32'd7);
        test_collision($urandom_range(2, 8), 32'($urandom_range(1, 50)));
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
